// File: rtl/debounce_pkg.sv
// Shared constants and the counter-width helper for the debouncer block.
package debounce_pkg;

    localparam int DEFAULT_CHANNELS        = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;
    localparam int DEFAULT_HOLD_CYCLES     = 0;

    // Bits needed to hold values 0..n inclusive, never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchroniser, stable level with acceptance
// counter, press/release pulses and an optional long-press (hold) pulse.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int   HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic pressed,
    output logic press,
    output logic release_pulse,
    output logic hold
);

    localparam int            CW     = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          accept;

    // A change is accepted on the edge that sees the DEBOUNCE_CYCLES-th
    // consecutive sample differing from the stable level.
    assign accept  = (sync_b != stable) && (cnt == C_LAST);
    assign pressed = stable ^ IDLE_LEVEL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a        <= IDLE_LEVEL;
            sync_b        <= IDLE_LEVEL;
            stable        <= IDLE_LEVEL;
            cnt           <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_a        <= in;
            sync_b        <= sync_a;
            press         <= accept && (sync_b != IDLE_LEVEL);
            release_pulse <= accept && (sync_b == IDLE_LEVEL);
            if (sync_b == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync_b;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    generate
        if (HOLD_CYCLES > 0) begin : g_hold
            localparam int            HW     = cnt_width(HOLD_CYCLES);
            localparam logic [HW-1:0] H_MAX  = HW'(HOLD_CYCLES);
            localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);

            logic [HW-1:0] hcnt;
            logic          hold_q;

            // Saturating count of cycles spent pressed; the pulse fires on the
            // edge that reaches H_MAX unless a release is accepted on that edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hcnt   <= '0;
                    hold_q <= 1'b0;
                end else begin
                    hold_q <= 1'b0;
                    if (!pressed) begin
                        hcnt <= '0;
                    end else if (hcnt != H_MAX) begin
                        hcnt   <= hcnt + HW'(1);
                        hold_q <= (hcnt == H_LAST) && !accept;
                    end
                end
            end

            assign hold = hold_q;
        end else begin : g_no_hold
            assign hold = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/multi_debouncer.sv
// CHANNELS independent debouncers plus a combined event flag.
// release/event are SystemVerilog keywords, hence release_pulse/event_pulse.
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int                  CHANNELS        = DEFAULT_CHANNELS,
    parameter int                  DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int                  HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter logic [CHANNELS-1:0] IDLE_LEVEL      = '1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] hold,
    output logic                event_pulse
);

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .HOLD_CYCLES     (HOLD_CYCLES),
                .IDLE_LEVEL      (IDLE_LEVEL[i])
            ) u_ch (
                .clk           (clk),
                .rst_n         (rst_n),
                .in            (in[i]),
                .pressed       (pressed[i]),
                .press         (press[i]),
                .release_pulse (release_pulse[i]),
                .hold          (hold[i])
            );
        end
    endgenerate

    assign event_pulse = (|press) | (|release_pulse);

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer with CHANNELS=4, DEBOUNCE_CYCLES=8,
// HOLD_CYCLES=32, IDLE_LEVEL=4'b1111.
module tb_multi_debouncer;

    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] in_sig;
    logic [CH-1:0] pressed;
    logic [CH-1:0] press;
    logic [CH-1:0] release_pulse;
    logic [CH-1:0] hold;
    logic          event_pulse;

    int errors = 0;
    int checks = 0;

    multi_debouncer #(
        .CHANNELS        (CH),
        .DEBOUNCE_CYCLES (8),
        .HOLD_CYCLES     (32),
        .IDLE_LEVEL      (4'b1111)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in            (in_sig),
        .pressed       (pressed),
        .press         (press),
        .release_pulse (release_pulse),
        .hold          (hold),
        .event_pulse   (event_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_pressed,
                             input logic [3:0] e_press, input logic [3:0] e_rel,
                             input logic [3:0] e_hold);
        check({tag, "_pressed"}, 32'(pressed), 32'(e_pressed));
        check({tag, "_press"}, 32'(press), 32'(e_press));
        check({tag, "_release"}, 32'(release_pulse), 32'(e_rel));
        check({tag, "_hold"}, 32'(hold), 32'(e_hold));
        check({tag, "_event"}, 32'(event_pulse), 32'(|{e_press, e_rel}));
    endtask

    // n cycles in which no pulse of any kind may appear
    task automatic quiet(input int n, input logic [3:0] e_pressed, input string tag);
        for (int k = 0; k < n; k++) begin
            step();
            check_all(tag, e_pressed, 4'b0000, 4'b0000, 4'b0000);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        in_sig = 4'b1111;

        // reset state
        quiet(3, 4'b0000, "reset");
        rst_n = 1'b1;
        quiet(5, 4'b0000, "idle");

        // single press on ch0: pulse on the 10th edge counting the sampling edge
        in_sig = 4'b1110;
        quiet(9, 4'b0000, "ch0_wait");
        step();
        check_all("ch0_press", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        in_sig = 4'b1111;
        quiet(9, 4'b0001, "ch0_held");
        step();
        check_all("ch0_release", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        quiet(3, 4'b0000, "ch0_after");

        // ch1: five 7-cycle glitches are all rejected
        for (int r = 0; r < 5; r++) begin
            in_sig = 4'b1101;
            quiet(7, 4'b0000, "ch1_glitch_low");
            in_sig = 4'b1111;
            quiet(5, 4'b0000, "ch1_glitch_high");
        end

        // ch2: held low 60 cycles -> press, hold 32 cycles later, release
        in_sig = 4'b1011;
        quiet(9, 4'b0000, "ch2_wait");
        step();
        check_all("ch2_press", 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        quiet(31, 4'b0100, "ch2_prehold");
        step();
        check_all("ch2_hold", 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        quiet(18, 4'b0100, "ch2_posthold");
        in_sig = 4'b1111;
        quiet(9, 4'b0100, "ch2_relwait");
        step();
        check_all("ch2_release", 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        quiet(3, 4'b0000, "ch2_after");

        // ch3: low 20 cycles -> press and release, no hold
        in_sig = 4'b0111;
        quiet(9, 4'b0000, "ch3_wait");
        step();
        check_all("ch3_press", 4'b1000, 4'b1000, 4'b0000, 4'b0000);
        quiet(10, 4'b1000, "ch3_held");
        in_sig = 4'b1111;
        quiet(9, 4'b1000, "ch3_relwait");
        step();
        check_all("ch3_release", 4'b0000, 4'b0000, 4'b1000, 4'b0000);
        quiet(3, 4'b0000, "ch3_after");

        // ch0 and ch2 together
        in_sig = 4'b1010;
        quiet(9, 4'b0000, "dual_wait");
        step();
        check_all("dual_press", 4'b0101, 4'b0101, 4'b0000, 4'b0000);
        in_sig = 4'b1111;
        quiet(9, 4'b0101, "dual_held");
        step();
        check_all("dual_release", 4'b0000, 4'b0000, 4'b0101, 4'b0000);
        quiet(2, 4'b0000, "dual_after");

        // reset 5 cycles into a debounce; input stays low throughout
        in_sig = 4'b1110;
        quiet(5, 4'b0000, "rst_pre");
        rst_n = 1'b0;
        #1;
        check_all("rst_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        quiet(2, 4'b0000, "rst_low");
        rst_n = 1'b1;
        quiet(9, 4'b0000, "rst_wait");
        step();
        check_all("rst_press", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        quiet(4, 4'b0001, "rst_held");

        // reset while pressed clears state without any pulse
        rst_n = 1'b0;
        #1;
        check_all("rst_pressed", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        in_sig = 4'b1111;
        quiet(2, 4'b0000, "rst2_low");
        rst_n = 1'b1;
        quiet(15, 4'b0000, "rst2_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
